delay_line_responder: RTL and testbench
=======================================

Name: delay_line_responder

Overview:
- Responder end of the smart_ram read interface used by the audio effect blocks.
- Holds a circular delay line of the most recent 2^ADDR_WIDTH audio samples, written once per sample period by the audio input path.
- Services offset-based read requests (sram_rd / sram_offset) from an effect, returning the sample written offset+1 writes ago.
- Returns the sample with a single-cycle sram_read_finish pulse after a fixed latency.

Parameters:
DATA_WIDTH, 16, sample width in bits
ADDR_WIDTH, 13, delay-line address width; depth = 2^ADDR_WIDTH words
READ_LATENCY, 2, cycles from request acceptance to sram_read_finish; legal range 1..15

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
sample_in  input  DATA_WIDTH  new audio sample for the delay line
sample_we  input  1  one-cycle write strobe; stores sample_in at the write pointer
sram_rd  input  1  read request strobe from the effect
sram_offset  input  ADDR_WIDTH  distance back from the newest sample (0 = newest)
sram_data_out  output  DATA_WIDTH  read data; valid when sram_read_finish=1, then held
sram_read_finish  output  1  one-cycle pulse marking read completion
busy  output  1  a read is in flight; new requests are ignored
wr_ptr_out  output  ADDR_WIDTH  current write pointer (next location to be written)
fill_level  output  ADDR_WIDTH+1  number of valid samples stored, saturating at 2^ADDR_WIDTH

Behaviour:
- Reset (rst=0, asynchronous):
  - wr_ptr=0, fill_level=0, state=IDLE.
  - sram_read_finish=0, busy=0, sram_data_out=0.
  - RAM contents are not cleared.
  - Reset mid-read aborts the read; no finish pulse is ever issued for it.
- Write path, when sample_we=1:
  - mem[wr_ptr] <= sample_in.
  - wr_ptr increments modulo 2^ADDR_WIDTH (wraps from 2^ADDR_WIDTH-1 to 0).
  - fill_level increments, saturating at 2^ADDR_WIDTH.
  - Writes are accepted in every state, including while busy.
- Read address: rd_addr = wr_ptr - 1 - sram_offset, modulo 2^ADDR_WIDTH.
  - Computed and latched in the acceptance cycle using the wr_ptr value before any write in that same cycle.
  - A write in the acceptance cycle therefore does not change the address.
  - Data is read from RAM at the end of the latency window. If a later write overwrites rd_addr inside the window (only possible near full depth), the newer data is returned.
- Unwritten-location guard:
  - Checked in the acceptance cycle: if sram_offset >= fill_level, the request is flagged empty.
  - An empty request returns 0 instead of RAM contents.
  - Handshake timing is unchanged for empty requests.
- State machine:
  - IDLE: if sram_rd=1, latch rd_addr and the empty flag, load the latency counter with READ_LATENCY-1, go to WAIT. Otherwise stay.
  - WAIT: busy=1. Decrement the counter each cycle. When the counter is 0, register the data into sram_data_out, pulse sram_read_finish for one cycle, return to IDLE.
  - Timing: a request accepted at cycle t gives sram_read_finish=1 at cycle t+READ_LATENCY. busy=1 for cycles t+1 .. t+READ_LATENCY.
- Request rules:
  - sram_rd while busy=1 is ignored: not queued, no finish pulse.
  - sram_rd held high for several cycles counts as one request at its first IDLE cycle. Later high cycles during busy are ignored.
  - sram_rd high in the finish cycle is ignored.
  - Minimum spacing between accepted requests is READ_LATENCY+1 cycles.
- sram_data_out holds its value until the next finish pulse.
- sram_offset = 2^ADDR_WIDTH-1 is legal. It returns the oldest sample only when fill_level is saturated; otherwise it returns 0.

Test Plan:
- Reset then read: rst low 3 cycles, release; sram_rd=1 with offset 0 at cycle t -> busy=1 at t+1..t+2, finish=1 at t+2 only, sram_data_out=0 (empty), fill_level=0.
- Basic delay: write 0x0001..0x000A (10 writes); read offset 0 -> 0x000A; offset 3 -> 0x0007; offset 9 -> 0x0001; offset 10 -> 0x0000 (empty guard); wr_ptr_out=10, fill_level=10.
- Wrap-around (ADDR_WIDTH=4): write 20 samples of value i (i=1..20) -> wr_ptr_out=4, fill_level=16; offset 0 -> 20, offset 15 -> 5, offset 5 -> 15.
- Simultaneous write and request: after 4 writes (values 1..4), pulse sample_we with value 0x00FF in the same cycle as sram_rd with offset 0 -> returns 4, not 0x00FF; a following read with offset 0 returns 0x00FF.
- Request while busy: sram_rd at t, again at t+1 and t+2 (READ_LATENCY=2) -> exactly one finish pulse at t+2; a request at t+3 is accepted, finish at t+5.
- Reset mid-read: sram_rd at t, rst low at t+1 -> no finish pulse ever; busy=0, wr_ptr_out=0, fill_level=0 immediately (asynchronous).

Source files
------------

// File: rtl/delay_line_responder_if.sv
// Read-request handshake between an audio effect (master) and the
// delay-line responder (slave).
interface delay_line_responder_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 13
);
  logic                  sram_rd;
  logic [ADDR_WIDTH-1:0] sram_offset;
  logic [DATA_WIDTH-1:0] sram_data_out;
  logic                  sram_read_finish;
  logic                  busy;

  modport master (
    output sram_rd, sram_offset,
    input  sram_data_out, sram_read_finish, busy
  );

  modport slave (
    input  sram_rd, sram_offset,
    output sram_data_out, sram_read_finish, busy
  );
endinterface

// File: rtl/delay_line_responder.sv
// Circular delay line of the most recent 2^ADDR_WIDTH samples with an
// offset-addressed, fixed-latency read port for audio effects.
module delay_line_responder #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 13,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_we,
  delay_line_responder_if.slave bus,
  output logic [ADDR_WIDTH-1:0] wr_ptr_out,
  output logic [ADDR_WIDTH:0]   fill_level
);

  localparam int unsigned     DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL  = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH:0]   r_fill;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic                  r_empty;
  logic [3:0]            r_cnt;
  logic [DATA_WIDTH-1:0] r_data_hold;
  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_accept;
  logic                  w_finish;
  logic [ADDR_WIDTH-1:0] w_rd_addr_calc;
  logic                  w_empty_calc;
  logic [DATA_WIDTH-1:0] w_rd_data;

  // Address and empty flag use the pre-write pointer and fill level.
  assign w_rd_addr_calc = r_wr_ptr - ADDR_WIDTH'(1) - bus.sram_offset;
  assign w_empty_calc   = ({1'b0, bus.sram_offset} >= r_fill);
  assign w_rd_data      = r_empty ? '0 : r_mem[r_rd_addr];

  // Sample storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (sample_we) r_mem[r_wr_ptr] <= sample_in;
  end

  // Write pointer and saturating fill level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_fill   <= '0;
    end else if (sample_we) begin
      r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      if (r_fill != FULL) r_fill <= r_fill + (ADDR_WIDTH+1)'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // FSM next state: accept in IDLE, finish when the latency counter expires.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.sram_rd) begin
          w_accept    = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_finish    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request capture and latency countdown.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_addr <= '0;
      r_empty   <= 1'b0;
      r_cnt     <= '0;
    end else if (w_accept) begin
      r_rd_addr <= w_rd_addr_calc;
      r_empty   <= w_empty_calc;
      r_cnt     <= 4'(READ_LATENCY - 1);
    end else if (r_state == S_WAIT && r_cnt != '0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // Hold register for read data between finish pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_data_hold <= '0;
    else if (w_finish) r_data_hold <= w_rd_data;
  end

  // Data is presented in the finish cycle itself via a bypass around the
  // hold register, so finish and data land together at t+READ_LATENCY.
  assign bus.sram_data_out    = w_finish ? w_rd_data : r_data_hold;
  assign bus.sram_read_finish = w_finish;
  assign bus.busy             = (r_state == S_WAIT);
  assign wr_ptr_out           = r_wr_ptr;
  assign fill_level           = r_fill;

endmodule

// File: tb/tb_delay_line_responder.sv
// Scoreboard bench for delay_line_responder (ADDR_WIDTH=4, READ_LATENCY=2).
module tb_delay_line_responder;
  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] sample_in = '0;
  logic          sample_we = 1'b0;
  logic [AW-1:0] wr_ptr_out;
  logic [AW:0]   fill_level;
  int            cyc = 0;
  int            n_tests = 0;
  int            n_fail = 0;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;
  exp_t q[$];

  delay_line_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  delay_line_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_in  (sample_in),
    .sample_we  (sample_we),
    .bus        (bus),
    .wr_ptr_out (wr_ptr_out),
    .fill_level (fill_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // Monitor: every finish pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (bus.sram_read_finish) begin
      n_tests++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_finish: cycle %0d data %h, required no finish", cyc, bus.sram_data_out);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (bus.sram_data_out !== e.data || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL read_data: got %h at cycle %0d, required %h at cycle %0d",
                   bus.sram_data_out, cyc, e.data, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic do_write(input logic [DW-1:0] v);
    sample_we = 1'b1;
    sample_in = v;
    tick();
    sample_we = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] off, input logic [DW-1:0] exp);
    bus.sram_rd     = 1'b1;
    bus.sram_offset = off;
    q.push_back('{exp, cyc + 2});
    tick();
    bus.sram_rd = 1'b0;
    repeat (3) tick();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    int t;
    bus.sram_rd     = 1'b0;
    bus.sram_offset = '0;

    // Reset, then a read of an empty delay line.
    repeat (3) tick();
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_finish", 32'(bus.sram_read_finish), 32'd0);
    check("reset_data", 32'(bus.sram_data_out), 32'd0);
    check("reset_wr_ptr", 32'(wr_ptr_out), 32'd0);
    check("reset_fill", 32'(fill_level), 32'd0);
    rst = 1'b1;
    tick();
    bus.sram_rd     = 1'b1;
    bus.sram_offset = '0;
    q.push_back('{16'h0000, cyc + 2});
    tick();
    bus.sram_rd = 1'b0;
    check("busy_t1", 32'(bus.busy), 32'd1);
    tick();
    check("busy_t2", 32'(bus.busy), 32'd1);
    tick();
    check("busy_t3", 32'(bus.busy), 32'd0);
    check("empty_fill", 32'(fill_level), 32'd0);

    // Basic delay: 10 writes.
    for (int i = 1; i <= 10; i++) do_write(16'(i));
    check("wr_ptr_10", 32'(wr_ptr_out), 32'd10);
    check("fill_10", 32'(fill_level), 32'd10);
    do_read(4'd0, 16'h000A);
    do_read(4'd3, 16'h0007);
    do_read(4'd9, 16'h0001);
    do_read(4'd10, 16'h0000);
    do_read(4'd15, 16'h0000);

    // Wrap-around: continue to 20 writes total.
    for (int i = 11; i <= 20; i++) do_write(16'(i));
    check("wr_ptr_wrap", 32'(wr_ptr_out), 32'd4);
    check("fill_sat", 32'(fill_level), 32'd16);
    do_read(4'd0, 16'd20);
    do_read(4'd15, 16'd5);
    do_read(4'd5, 16'd15);

    // Simultaneous write and request.
    do_reset();
    for (int i = 1; i <= 4; i++) do_write(16'(i));
    sample_we       = 1'b1;
    sample_in       = 16'h00FF;
    bus.sram_rd     = 1'b1;
    bus.sram_offset = '0;
    q.push_back('{16'h0004, cyc + 2});
    tick();
    sample_we   = 1'b0;
    bus.sram_rd = 1'b0;
    repeat (3) tick();
    do_read(4'd0, 16'h00FF);

    // Requests while busy are dropped; the next IDLE cycle is accepted.
    t = cyc;
    bus.sram_rd     = 1'b1;
    bus.sram_offset = 4'd0;
    q.push_back('{16'h00FF, t + 2});
    tick();
    bus.sram_offset = 4'd2;
    tick();
    tick();
    bus.sram_offset = 4'd1;
    q.push_back('{16'h0004, t + 5});
    tick();
    bus.sram_rd = 1'b0;
    repeat (4) tick();

    // Reset in the middle of a read.
    bus.sram_rd     = 1'b1;
    bus.sram_offset = 4'd0;
    tick();
    bus.sram_rd = 1'b0;
    rst = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_wr_ptr", 32'(wr_ptr_out), 32'd0);
    check("midrst_fill", 32'(fill_level), 32'd0);
    check("midrst_finish", 32'(bus.sram_read_finish), 32'd0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (6) tick();

    check("pending_reads", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
